// File: rtl/mips_pkg.sv
// Shared definitions for the MEM/WB pipeline stage: load-type codes and the
// layout of one buffered writeback entry.
package mips_pkg;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic        misalign;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/load_align.sv
// Combinational load lane selection, sign/zero extension and misalign
// detection for a little-endian 32-bit data memory word.
module load_align
  import mips_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  input  logic [2:0]  load_type_i,
  input  logic        mem_to_reg_i,
  output logic [31:0] load_data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_lane = rdata_i[{addr_i[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    load_data_o = rdata_i;
    misalign_o  = mem_to_reg_i && (addr_i != 2'b00);
    case (load_type_i)
      LT_LH: begin
        load_data_o = {{16{half_lane[15]}}, half_lane};
        misalign_o  = mem_to_reg_i && addr_i[0];
      end
      LT_LHU: begin
        load_data_o = {16'h0000, half_lane};
        misalign_o  = mem_to_reg_i && addr_i[0];
      end
      LT_LB: begin
        load_data_o = {{24{byte_lane[7]}}, byte_lane};
        misalign_o  = 1'b0;
      end
      LT_LBU: begin
        load_data_o = {24'h000000, byte_lane};
        misalign_o  = 1'b0;
      end
      default: ;  // LW and the unused codes 5-7 keep the word defaults
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: a 2-entry skid FIFO holding fully aligned load data,
// so writeback outputs come straight from registers.
module mem_wb_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_mem_rdata,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic [2:0]  in_load_type,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_load_data,
  output logic        out_mem_to_reg,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_misalign
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0] state_q, state_d;
  wb_entry_t  head_q, head_d;
  wb_entry_t  tail_q, tail_d;
  wb_entry_t  new_entry;
  logic       push, pop;

  load_align u_load_align (
    .addr_i       (in_alu_result[1:0]),
    .rdata_i      (in_mem_rdata),
    .load_type_i  (in_load_type),
    .mem_to_reg_i (in_mem_to_reg),
    .load_data_o  (new_entry.load_data),
    .misalign_o   (new_entry.misalign)
  );

  assign new_entry.alu_result = in_alu_result;
  assign new_entry.rd         = in_rd;
  assign new_entry.reg_write  = in_reg_write;
  assign new_entry.mem_to_reg = in_mem_to_reg;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
        ONE: begin
          if (push && !pop) begin
            tail_d  = new_entry;
            state_d = TWO;
          end else if (pop && !push) begin
            head_d  = '0;
            state_d = EMPTY;
          end else if (push && pop) begin
            head_d  = new_entry;
          end
        end
        TWO: if (pop) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = ONE;
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          tail_d  = '0;
        end
      endcase
    end
  end

  // NOTE: entry storage is reset too, so an idle stage presents all-zero data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment only.
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_alu_result = out_valid ? head_q.alu_result : 32'h0;
  assign out_load_data  = out_valid ? head_q.load_data  : 32'h0;
  assign out_mem_to_reg = out_valid && head_q.mem_to_reg;
  assign out_rd         = out_valid ? head_q.rd : 5'd0;
  assign out_misalign   = out_valid && head_q.misalign;
  // A misaligned load or a write to x0 must never reach the register file.
  assign out_reg_write  = out_valid && head_q.reg_write && (head_q.rd != 5'd0)
                          && !head_q.misalign;

endmodule
